// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite word RAM responder with programmable wait states and two-cycle ERROR for illegal transfers.
// Optional AHB_SLV_ERR_COUNT_EN adds a saturating err_count output counting ERROR responses.
module ahb_lite_slave_mem #(
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hready_out,
  output logic        hresp,
  output logic [31:0] hr_data
`ifdef AHB_SLV_ERR_COUNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam int          AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH) << 2;
  localparam logic [3:0]  WS_LOAD   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  logic [31:0] mem [MEM_DEPTH];

  state_t      state_q, state_d;
  logic [AW+1:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept, addr_err, can_accept;
  logic [3:0]  be;
  logic        mem_we;
  logic        unused_htrans;

  assign unused_htrans = htrans[0];
  assign accept        = hsel & hready & htrans[1];

  always_comb begin
    addr_err = hsize[2]
             | (hsize[1:0] == 2'b11)
             | ((hsize[1:0] == 2'b01) & haddr[0])
             | ((hsize[1:0] == 2'b10) & (haddr[1:0] != 2'b00))
             | ({1'b0, haddr} >= MEM_BYTES);
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    size_d     = size_q;
    cnt_d      = cnt_q;
    hready_out = 1'b1;
    hresp      = 1'b0;
    can_accept = 1'b0;
    case (state_q)
      S_IDLE: can_accept = 1'b1;
      S_WAIT: begin
        hready_out = 1'b0;
        if (cnt_q == 4'd0) state_d = S_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_DATA: can_accept = 1'b1;
      S_ERR1: begin
        hready_out = 1'b0;
        hresp      = 1'b1;
        state_d    = S_ERR2;
      end
      S_ERR2: begin
        hresp      = 1'b1;
        can_accept = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Only states driving hready_out=1 can see a new address phase complete.
    if (can_accept) begin
      state_d = S_IDLE;
      if (accept) begin
        addr_d  = haddr[AW+1:0];
        write_d = hwrite;
        size_d  = hsize[1:0];
        cnt_d   = WS_LOAD;
        if (addr_err)             state_d = S_ERR1;
        else if (WAIT_STATES > 0) state_d = S_WAIT;
        else                      state_d = S_DATA;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    be = 4'b0000;
    case (size_q)
      2'b00:   be = 4'b0001 << addr_q[1:0];
      2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  assign mem_we = (state_q == S_DATA) && write_q;

  // RAM array deliberately has no reset so contents survive a bus reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem[addr_q[AW+1:2]][8*l +: 8] <= hwdata[8*l +: 8];
      end
    end
  end

  assign hr_data = ((state_q == S_DATA) && !write_q) ? mem[addr_q[AW+1:2]] : 32'h0;

`ifdef AHB_SLV_ERR_COUNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                         err_cnt_q <= 16'h0;
    else if (state_d == S_ERR1 && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'h1;
  end

  assign err_count = err_cnt_q;
`endif

endmodule
